nibble_serial_adder: RTL

Multi-cycle WIDTH-bit adder that processes operands one 4-bit nibble per clock, least significant nibble first. It keeps a registered carry between nibbles, so each cycle does the same work as the team's 4-bit propagate-adder slice. It sits directly upstream of result consumers and downstream of operand producers, with valid/ready handshakes on both sides. Wide additions run through a single narrow adder slice with a fixed, predictable latency.

---
 rtl/nibble_serial_adder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder built around a single 4-bit slice. Operands are
//   latched on the input handshake, then one nibble is added per clock, least
//   significant first, with the carry held in a register between nibbles.
//   The result is presented with a valid/ready handshake and held until taken.
//
//   state | meaning
//   IDLE  | waiting for an operand bundle; in_ready high
//   RUN   | adding one nibble per cycle; busy high
//   DONE  | result valid; waiting for the consumer to take it
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand bundle (a, b, cin) valid
//   in_ready   block can accept an operand bundle (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry into nibble 0
//   out_valid  sum/cout/ovf valid (DONE)
//   out_ready  consumer accepts the result
//   sum        registered result, (a + b + cin) mod 2^WIDTH
//   cout       carry out of the MSB
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   busy       high while in RUN

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBS = WIDTH / 4;
    localparam int IW   = (NIBS > 1) ? $clog2(NIBS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(NIBS - 1);

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       nib_sum;
    logic [3:0]       low3_sum;
    logic [IW+1:0]    bit_base;

    // Bit offset of the current nibble: idx * 4.
    assign bit_base = {idx, 2'b00};
    assign a_nib    = a_lat[bit_base +: 4];
    assign b_nib    = b_lat[bit_base +: 4];
    assign nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    // Sum of the low three bits exposes the carry into bit 3 for overflow.
    assign low3_sum = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry};

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_lat <= '0;
            b_lat <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_lat <= a;
                        b_lat <= b;
                        carry <= cin;
                        sum   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[bit_base +: 4] <= nib_sum[3:0];
                    carry              <= nib_sum[4];
                    if (idx == LAST_IDX) begin
                        cout  <= nib_sum[4];
                        ovf   <= low3_sum[3] ^ nib_sum[4];
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
